// File: rtl/voice_scheduler.sv
// voice_scheduler: maps the two held MIDI keys onto two stable oscillator
// slots and commits slot changes only on vsync rising edges. A frame
// cooldown separates consecutive commits.
module voice_scheduler #(
    parameter int BASE_KEY        = 48,
    parameter int COOLDOWN_FRAMES = 2,
    parameter int CNT_W           = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             midi_ready,
    input  logic [6:0]       key1_index,
    input  logic [6:0]       key2_index,
    input  logic             vsync,
    output logic [4:0]       freq_id1,
    output logic [4:0]       freq_id2,
    output logic             freq_valid1,
    output logic             freq_valid2,
    output logic             new_freq,
    output logic             pending,
    output logic [CNT_W-1:0] commit_count,
    output logic [CNT_W-1:0] coalesce_count
);

    localparam int         CD_W   = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [6:0] KEY_LO = 7'(BASE_KEY);
    localparam logic [6:0] KEY_HI = 7'(BASE_KEY + 31);

    typedef enum logic {
        READY,
        COOLDOWN
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [CD_W-1:0]   cnt_reg;
    logic [CD_W-1:0]   cnt_next;
    logic              commit;

    logic              prev_vsync;
    logic              vs_rise;

    // Pending (uncommitted) slot assignment.
    logic [4:0]        pend_id1;
    logic [4:0]        pend_id2;
    logic              pend_v1;
    logic              pend_v2;
    logic              pend_valid;

    // Decoded notes.
    logic              n1_v;
    logic              n2_v;
    logic [4:0]        n1_id;
    logic [4:0]        n2_id;

    // Basis the new event is evaluated against.
    logic              b_v1;
    logic              b_v2;
    logic [4:0]        b_id1;
    logic [4:0]        b_id2;

    // New slot assignment.
    logic              keep1;
    logic              keep2;
    logic              rem1;
    logic              rem2;
    logic              res_v1;
    logic              res_v2;
    logic [4:0]        res_id1;
    logic [4:0]        res_id2;

    // Committed values the new assignment is compared against.
    logic              t_v1;
    logic              t_v2;
    logic [4:0]        t_id1;
    logic [4:0]        t_id2;
    logic              differs;
    logic              coalesce;

    // A key is playable only inside the 32-key window starting at BASE_KEY.
    function automatic logic key_ok(input logic [6:0] key);
        return (key != 7'd0) && (key >= KEY_LO) && (key <= KEY_HI);
    endfunction

    function automatic logic [4:0] key_id(input logic [6:0] key);
        return 5'(key - KEY_LO);
    endfunction

    assign vs_rise = vsync & ~prev_vsync;
    assign pending = pend_valid;

    // Decode keys into at most two distinct notes; a duplicate second key is dropped.
    always_comb begin
        n1_v  = key_ok(key1_index);
        n1_id = key_id(key1_index);
        n2_id = key_id(key2_index);
        n2_v  = key_ok(key2_index) && !(n1_v && (n2_id == n1_id));
    end

    // Select the basis: the pending assignment if one exists, else the committed slots.
    always_comb begin
        if (pend_valid) begin
            b_v1  = pend_v1;
            b_id1 = pend_id1;
            b_v2  = pend_v2;
            b_id2 = pend_id2;
        end else begin
            b_v1  = freq_valid1;
            b_id1 = freq_id1;
            b_v2  = freq_valid2;
            b_id2 = freq_id2;
        end
    end

    // Keep slots whose note is still held, then place the remaining notes in free slots.
    always_comb begin
        keep1 = b_v1 && ((n1_v && (b_id1 == n1_id)) || (n2_v && (b_id1 == n2_id)));
        keep2 = b_v2 && ((n1_v && (b_id2 == n1_id)) || (n2_v && (b_id2 == n2_id)));
        rem1  = n1_v && !(keep1 && (b_id1 == n1_id)) && !(keep2 && (b_id2 == n1_id));
        rem2  = n2_v && !(keep1 && (b_id1 == n2_id)) && !(keep2 && (b_id2 == n2_id));

        // Unplaced slots are silenced but keep their previous id.
        res_v1  = keep1;
        res_id1 = b_id1;
        res_v2  = keep2;
        res_id2 = b_id2;

        if (rem1) begin
            if (!res_v1) begin
                res_v1  = 1'b1;
                res_id1 = n1_id;
            end else if (!res_v2) begin
                res_v2  = 1'b1;
                res_id2 = n1_id;
            end
        end
        if (rem2) begin
            if (!res_v1) begin
                res_v1  = 1'b1;
                res_id1 = n2_id;
            end else if (!res_v2) begin
                res_v2  = 1'b1;
                res_id2 = n2_id;
            end
        end
    end

    // Compare the new assignment with the committed slots (including a commit happening now).
    always_comb begin
        if (commit) begin
            t_v1  = pend_v1;
            t_id1 = pend_id1;
            t_v2  = pend_v2;
            t_id2 = pend_id2;
        end else begin
            t_v1  = freq_valid1;
            t_id1 = freq_id1;
            t_v2  = freq_valid2;
            t_id2 = freq_id2;
        end
        differs = (res_v1 != t_v1) || (res_v1 && t_v1 && (res_id1 != t_id1)) ||
                  (res_v2 != t_v2) || (res_v2 && t_v2 && (res_id2 != t_id2));
        // An event landing on a commit edge starts a new pending set, not a coalesce.
        coalesce = midi_ready && pend_valid && !commit && differs;
    end

    // Commit FSM: next state, cooldown count and commit strobe.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        commit     = 1'b0;
        case (state_reg)
            READY: begin
                if (vs_rise && pend_valid) begin
                    commit = 1'b1;
                    if (COOLDOWN_FRAMES != 0) begin
                        state_next = COOLDOWN;
                        cnt_next   = CD_W'(COOLDOWN_FRAMES);
                    end
                end
            end
            COOLDOWN: begin
                if (vs_rise) begin
                    if (cnt_reg == CD_W'(1)) begin
                        state_next = READY;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg - CD_W'(1);
                    end
                end
            end
            default: begin
                state_next = READY;
                cnt_next   = '0;
            end
        endcase
    end

    // FSM state and cooldown counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= READY;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Delayed vsync for rising-edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_vsync <= 1'b0;
        end else begin
            prev_vsync <= vsync;
        end
    end

    // Capture each MIDI event into the pending set; a commit retires it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_id1   <= '0;
            pend_id2   <= '0;
            pend_v1    <= 1'b0;
            pend_v2    <= 1'b0;
            pend_valid <= 1'b0;
        end else if (midi_ready) begin
            pend_id1   <= res_id1;
            pend_id2   <= res_id2;
            pend_v1    <= res_v1;
            pend_v2    <= res_v2;
            pend_valid <= differs;
        end else if (commit) begin
            pend_valid <= 1'b0;
        end
    end

    // Committed slot outputs and the one-cycle change strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            freq_id1    <= '0;
            freq_id2    <= '0;
            freq_valid1 <= 1'b0;
            freq_valid2 <= 1'b0;
            new_freq    <= 1'b0;
        end else begin
            new_freq <= commit;
            if (commit) begin
                freq_id1    <= pend_id1;
                freq_id2    <= pend_id2;
                freq_valid1 <= pend_v1;
                freq_valid2 <= pend_v2;
            end
        end
    end

    // Diagnostic counters, wrapping silently.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            commit_count   <= '0;
            coalesce_count <= '0;
        end else begin
            if (commit) begin
                commit_count <= commit_count + CNT_W'(1);
            end
            if (coalesce) begin
                coalesce_count <= coalesce_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Testbench for voice_scheduler: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a behavioural model.
module tb_voice_scheduler;

    localparam int BASE_KEY        = 48;
    localparam int COOLDOWN_FRAMES = 2;
    localparam int CNT_W           = 8;

    logic             clock      = 1'b0;
    logic             reset_n    = 1'b0;
    logic             midi_ready = 1'b0;
    logic [6:0]       key1_index = '0;
    logic [6:0]       key2_index = '0;
    logic             vsync      = 1'b0;
    logic [4:0]       freq_id1;
    logic [4:0]       freq_id2;
    logic             freq_valid1;
    logic             freq_valid2;
    logic             new_freq;
    logic             pending;
    logic [CNT_W-1:0] commit_count;
    logic [CNT_W-1:0] coalesce_count;

    int errors = 0;
    int checks = 0;

    voice_scheduler #(
        .BASE_KEY(BASE_KEY),
        .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
        .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .midi_ready(midi_ready),
        .key1_index(key1_index),
        .key2_index(key2_index),
        .vsync(vsync),
        .freq_id1(freq_id1),
        .freq_id2(freq_id2),
        .freq_valid1(freq_valid1),
        .freq_valid2(freq_valid2),
        .new_freq(new_freq),
        .pending(pending),
        .commit_count(commit_count),
        .coalesce_count(coalesce_count)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural reference model ----------------
    bit m_v[2];
    int m_id[2];
    bit p_v[2];
    int p_id[2];
    bit p_flag;
    int rises_since;
    bit m_prev_vs;
    int m_cc;
    int m_co;
    bit m_nf;

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_v[s]  = 1'b0;
            m_id[s] = 0;
            p_v[s]  = 1'b0;
            p_id[s] = 0;
        end
        p_flag      = 1'b0;
        rises_since = 1000;
        m_prev_vs   = 1'b0;
        m_cc        = 0;
        m_co        = 0;
        m_nf        = 1'b0;
    endtask

    // One clock edge of the model, given the inputs present during that cycle.
    task automatic model_step(input bit midi, input int k1, input int k2, input bit vs);
        bit rise;
        int notes[$];
        int keys[2];
        bit bv[2];
        int bid[2];
        bit rv[2];
        int rid[2];
        bit diff;
        rise      = vs && !m_prev_vs;
        m_prev_vs = vs;
        m_nf      = 1'b0;
        if (rise) begin
            if (rises_since < 1000) rises_since++;
            // A commit needs more than COOLDOWN_FRAMES rises since the previous one.
            if (p_flag && rises_since > COOLDOWN_FRAMES) begin
                m_v         = p_v;
                m_id        = p_id;
                p_flag      = 1'b0;
                m_cc++;
                m_nf        = 1'b1;
                rises_since = 0;
            end
        end
        if (midi) begin
            keys[0] = k1;
            keys[1] = k2;
            for (int i = 0; i < 2; i++) begin
                if (keys[i] != 0 && keys[i] >= BASE_KEY && keys[i] <= BASE_KEY + 31) begin
                    bit seen;
                    seen = 1'b0;
                    foreach (notes[j]) if (notes[j] == keys[i] - BASE_KEY) seen = 1'b1;
                    if (!seen) notes.push_back(keys[i] - BASE_KEY);
                end
            end
            if (p_flag) begin
                bv  = p_v;
                bid = p_id;
            end else begin
                bv  = m_v;
                bid = m_id;
            end
            for (int s = 0; s < 2; s++) begin
                rv[s]  = 1'b0;
                rid[s] = bid[s];
                if (bv[s]) foreach (notes[j]) if (notes[j] == bid[s]) rv[s] = 1'b1;
            end
            foreach (notes[j]) begin
                bit placed;
                placed = 1'b0;
                for (int s = 0; s < 2; s++) if (rv[s] && rid[s] == notes[j]) placed = 1'b1;
                for (int s = 0; s < 2; s++) begin
                    if (!placed && !rv[s]) begin
                        rv[s]  = 1'b1;
                        rid[s] = notes[j];
                        placed = 1'b1;
                    end
                end
            end
            diff = 1'b0;
            for (int s = 0; s < 2; s++) begin
                if (rv[s] != m_v[s] || (rv[s] && m_v[s] && rid[s] != m_id[s])) diff = 1'b1;
            end
            if (diff && p_flag) m_co++;
            p_flag = diff;
            p_v    = rv;
            p_id   = rid;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_compare();
        check("model_slots", {20'd0, freq_id1, freq_valid1, freq_id2, freq_valid2},
              {20'd0, 5'(m_id[0]), m_v[0], 5'(m_id[1]), m_v[1]});
        check("model_flags", {30'd0, new_freq, pending}, {30'd0, m_nf, p_flag});
        check("model_counts", {16'd0, commit_count, coalesce_count},
              {16'd0, CNT_W'(m_cc), CNT_W'(m_co)});
    endtask

    task automatic expect_out(input string name, input int id1, input int v1, input int id2,
                              input int v2, input int nf, input int pend, input int cc,
                              input int co);
        check(name,
              {2'd0, freq_id1, freq_valid1, freq_id2, freq_valid2, new_freq, pending,
               commit_count, coalesce_count},
              {2'd0, 5'(id1), 1'(v1), 5'(id2), 1'(v2), 1'(nf), 1'(pend), CNT_W'(cc), CNT_W'(co)});
    endtask

    // Drive one cycle of inputs, advance the model on the edge, compare just after it.
    task automatic apply(input bit midi, input int k1, input int k2, input bit vs);
        midi_ready = midi;
        key1_index = 7'(k1);
        key2_index = 7'(k2);
        vsync      = vs;
        @(posedge clock);
        model_step(midi, k1, k2, vs);
        #1;
        model_compare();
    endtask

    task automatic hard_reset();
        reset_n    = 1'b0;
        midi_ready = 1'b0;
        key1_index = '0;
        key2_index = '0;
        vsync      = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        expect_out("reset_state", 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int rkey();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 2) return 0;
        if (r == 2) return int'($urandom_range(1, 127));
        return BASE_KEY + int'($urandom_range(0, 7));
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit midi;
        int k1;
        int k2;
        bit vs;
        bit chk;
        int id1;
        int v1;
        int id2;
        int v2;
        int nf;
        int pend;
        int cc;
        int co;
    } vec_t;

    vec_t tbl[$];

    task automatic add_ck(input bit midi, input int k1, input int k2, input bit vs,
                          input int id1, input int v1, input int id2, input int v2,
                          input int nf, input int pend, input int cc, input int co);
        vec_t r;
        r.midi = midi; r.k1 = k1; r.k2 = k2; r.vs = vs; r.chk = 1'b1;
        r.id1 = id1; r.v1 = v1; r.id2 = id2; r.v2 = v2;
        r.nf = nf; r.pend = pend; r.cc = cc; r.co = co;
        tbl.push_back(r);
    endtask

    task automatic add_vs(input bit vs);
        vec_t r;
        r.midi = 1'b0; r.k1 = 0; r.k2 = 0; r.vs = vs; r.chk = 1'b0;
        r.id1 = 0; r.v1 = 0; r.id2 = 0; r.v2 = 0;
        r.nf = 0; r.pend = 0; r.cc = 0; r.co = 0;
        tbl.push_back(r);
    endtask

    initial begin
        // Single note, commit one frame later.
        add_ck(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        add_ck(1, 60, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0);
        add_ck(0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0, 0);
        add_ck(0, 0, 0, 1,   12, 1, 0, 0, 1, 0, 1, 0);
        add_ck(0, 0, 0, 1,   12, 1, 0, 0, 0, 0, 1, 0);
        add_vs(0); add_vs(1); add_vs(0); add_vs(1); add_vs(0);
        // Held note stays in slot 1, new note fills slot 2.
        add_ck(1, 72, 60, 0, 12, 1, 0, 0, 0, 1, 1, 0);
        add_ck(0, 0, 0, 1,   12, 1, 24, 1, 1, 0, 2, 0);
        add_vs(0);
        // Release of key 60 silences slot 1 but keeps its id; cooldown delays it.
        add_ck(1, 72, 0, 0,  12, 1, 24, 1, 0, 1, 2, 0);
        add_ck(0, 0, 0, 1,   12, 1, 24, 1, 0, 1, 2, 0);
        add_vs(0);
        add_ck(0, 0, 0, 1,   12, 1, 24, 1, 0, 1, 2, 0);
        add_vs(0);
        add_ck(0, 0, 0, 1,   12, 0, 24, 1, 1, 0, 3, 0);
        add_ck(0, 0, 0, 0,   12, 0, 24, 1, 0, 0, 3, 0);
        add_vs(1); add_vs(0); add_vs(1); add_vs(0);
        // Burst of three events coalesces into one commit.
        add_ck(1, 50, 0, 0,  12, 0, 24, 1, 0, 1, 3, 0);
        add_ck(1, 55, 0, 0,  12, 0, 24, 1, 0, 1, 3, 1);
        add_ck(1, 57, 0, 0,  12, 0, 24, 1, 0, 1, 3, 2);
        add_ck(0, 0, 0, 1,   9, 1, 24, 0, 1, 0, 4, 2);
        add_ck(0, 0, 0, 0,   9, 1, 24, 0, 0, 0, 4, 2);

        hard_reset();
        foreach (tbl[i]) begin
            apply(tbl[i].midi, tbl[i].k1, tbl[i].k2, tbl[i].vs);
            if (tbl[i].chk) begin
                expect_out($sformatf("vec%0d", i), tbl[i].id1, tbl[i].v1, tbl[i].id2,
                           tbl[i].v2, tbl[i].nf, tbl[i].pend, tbl[i].cc, tbl[i].co);
            end
        end

        // Out-of-range keys are ignored; duplicate keys make one note.
        hard_reset();
        apply(1, 40, 100, 0);
        expect_out("oor_event", 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 1);
        expect_out("oor_vsync", 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0);
        apply(1, 60, 60, 0);
        expect_out("dup_event", 0, 0, 0, 0, 0, 1, 0, 0);
        apply(0, 0, 0, 1);
        expect_out("dup_commit", 12, 1, 0, 0, 1, 0, 1, 0);

        // Event coincident with a committing vsync edge.
        apply(0, 0, 0, 0); apply(0, 0, 0, 1); apply(0, 0, 0, 0); apply(0, 0, 0, 1);
        apply(0, 0, 0, 0);
        apply(1, 72, 0, 0);
        expect_out("pre_coinc", 12, 1, 0, 0, 0, 1, 1, 0);
        apply(1, 60, 72, 1);
        expect_out("coinc_commit", 24, 1, 0, 0, 1, 1, 2, 0);
        apply(0, 0, 0, 0);
        apply(0, 0, 0, 1);
        expect_out("coinc_cd1", 24, 1, 0, 0, 0, 1, 2, 0);
        apply(0, 0, 0, 0);
        apply(0, 0, 0, 1);
        expect_out("coinc_cd2", 24, 1, 0, 0, 0, 1, 2, 0);
        apply(0, 0, 0, 0);
        apply(0, 0, 0, 1);
        expect_out("coinc_late", 24, 1, 12, 1, 1, 0, 3, 0);

        // Asynchronous reset mid-cooldown with a pending assignment.
        apply(0, 0, 0, 0);
        apply(1, 50, 0, 0);
        expect_out("cd_pending", 24, 1, 12, 1, 0, 1, 3, 0);
        apply(0, 0, 0, 1);
        #2;
        reset_n    = 1'b0;
        vsync      = 1'b0;
        midi_ready = 1'b0;
        #1;
        expect_out("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        apply(0, 0, 0, 0);
        apply(0, 0, 0, 1);
        expect_out("post_reset_vs1", 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0);
        apply(0, 0, 0, 1);
        expect_out("post_reset_vs2", 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0);
        apply(1, 60, 0, 0);
        expect_out("fresh_event", 0, 0, 0, 0, 0, 1, 0, 0);
        apply(0, 0, 0, 1);
        expect_out("fresh_commit", 12, 1, 0, 0, 1, 0, 1, 0);

        // Randomized traffic against the model.
        begin
            int hold;
            bit vsl;
            bit midi;
            int k1;
            int k2;
            hold = 0;
            vsl  = 1'b0;
            for (int c = 0; c < 800; c++) begin
                if (hold == 0) begin
                    vsl  = !vsl;
                    hold = int'($urandom_range(1, 4));
                end
                hold--;
                midi = ($urandom_range(0, 9) < 3);
                k1   = rkey();
                k2   = ($urandom_range(0, 4) == 0) ? k1 : rkey();
                apply(midi, k1, k2, vsl);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
